pc_gen: RTL and testbench

Fetch-stage program-counter generator for the pipelined MIPS core. It owns the fetch PC register and advances it by 4 each cycle. It applies control-flow redirects (branch, j/jal, jr/jalr) raised by the decode stage, including the architectural delay slot. A one-entry pending-redirect buffer keeps a redirect that arrives during a fetch stall until the stall releases. Width and reset vector are parameters.

---
 rtl/pc_gen.sv | 126 ++++++++++++
 tb/tb_pc_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with delay-slot redirects and a one-entry pending-redirect buffer
// Optional macro PC_ADEL_EN enables the fetch address-error flag against PC_LO..PC_HI.
module pc_gen #(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_LO    = 32'h0000_3000,
  parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             d_valid,
  input  logic [2:0]       sel,
  input  logic             cmp,
  input  logic [WIDTH-1:0] pc_d,
  input  logic [25:0]      imm26,
  input  logic [WIDTH-1:0] jr,
  output logic [WIDTH-1:0] pc_f,
  output logic [WIDTH-1:0] pc4_f,
  output logic [WIDTH-1:0] pc8_d,
  output logic             redirect,
  output logic             pend_v,
  output logic             adel_f
);

  localparam logic IDLE = 1'b0;
  localparam logic PEND = 1'b1;
  localparam logic [WIDTH-1:0] RESET_VAL = RESET_PC[WIDTH-1:0];
  localparam logic [WIDTH-1:0] FOUR      = WIDTH'(4);
  localparam logic [WIDTH-1:0] EIGHT     = WIDTH'(8);

  if (WIDTH < 28 || WIDTH > 32) begin : g_bad_width
    $error("pc_gen: WIDTH must be within 28..32");
  end
  if (PC_LO > PC_HI) begin : g_bad_range
    $error("pc_gen: PC_LO must not exceed PC_HI");
  end

  logic             state_q, state_d;
  logic [WIDTH-1:0] fpc_q, fpc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic [WIDTH-1:0] pc4_dec;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] j_tgt;
  logic [WIDTH-1:0] tgt;

  assign pc4_dec = pc_d + FOUR;
  assign br_tgt  = pc4_dec + {{(WIDTH-18){imm26[15]}}, imm26[15:0], 2'b00};

  // Region bits above the 256 MB jump window exist only when WIDTH > 28.
  if (WIDTH > 28) begin : g_j_upper
    assign j_tgt = {pc4_dec[WIDTH-1:28], imm26, 2'b00};
  end else begin : g_j_flat
    assign j_tgt = {imm26, 2'b00};
  end

  always_comb begin
    tgt      = '0;
    redirect = 1'b0;
    case (sel)
      3'd1: begin
        tgt      = br_tgt;
        redirect = d_valid && cmp;
      end
      3'd2: begin
        tgt      = j_tgt;
        redirect = d_valid;
      end
      3'd3: begin
        tgt      = jr;
        redirect = d_valid;
      end
      default: begin
        tgt      = '0;
        redirect = 1'b0;
      end
    endcase
  end

  // A live redirect always wins over the buffered one; during a stall it replaces it.
  always_comb begin
    fpc_d      = fpc_q;
    state_d    = state_q;
    pend_tgt_d = pend_tgt_q;
    if (stall) begin
      if (redirect) begin
        state_d    = PEND;
        pend_tgt_d = tgt;
      end
    end else if (redirect) begin
      fpc_d   = tgt;
      state_d = IDLE;
    end else if (state_q == PEND) begin
      fpc_d   = pend_tgt_q;
      state_d = IDLE;
    end else begin
      fpc_d = fpc_q + FOUR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q      <= RESET_VAL;
      state_q    <= IDLE;
      pend_tgt_q <= '0;
    end else begin
      fpc_q      <= fpc_d;
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc_f   = fpc_q;
  assign pc4_f  = fpc_q + FOUR;
  assign pc8_d  = pc_d + EIGHT;
  assign pend_v = (state_q == PEND);

`ifdef PC_ADEL_EN
  logic [31:0] pc_ext;
  assign pc_ext = 32'(fpc_q);
  assign adel_f = (fpc_q[1:0] != 2'b00) || (pc_ext < PC_LO) || (pc_ext > PC_HI);
`else
  assign adel_f = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - table-driven scoreboard bench for pc_gen
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset, stall, d_valid, cmp;
  logic [2:0]  sel;
  logic [31:0] pc_d, jr;
  logic [25:0] imm26;
  logic [31:0] pc_f, pc4_f, pc8_d;
  logic        redirect, pend_v, adel_f;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .reset(reset), .stall(stall), .d_valid(d_valid), .sel(sel),
    .cmp(cmp), .pc_d(pc_d), .imm26(imm26), .jr(jr), .pc_f(pc_f), .pc4_f(pc4_f),
    .pc8_d(pc8_d), .redirect(redirect), .pend_v(pend_v), .adel_f(adel_f)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic        dv;
    logic [2:0]  sl;
    logic        cp;
    logic [31:0] pcd;
    logic [25:0] imm;
    logic [31:0] jrv;
    logic        e_redir;
    logic [31:0] e_pc;
    logic        e_pend;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        pend;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic logic adel_model(input logic [31:0] pc);
`ifdef PC_ADEL_EN
    return (pc[1:0] != 2'b00) || (pc < 32'h3000) || (pc > 32'h6FFC);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic stl, input logic dv, input logic [2:0] sl,
                     input logic cp, input logic [31:0] pcd, input logic [25:0] imm,
                     input logic [31:0] jrv, input logic e_redir, input logic [31:0] e_pc,
                     input logic e_pend);
    vec_t v;
    v = '{rst, stl, dv, sl, cp, pcd, imm, jrv, e_redir, e_pc, e_pend};
    vecs.push_back(v);
  endtask

  // Drive one cycle, check combinational outputs mid-cycle, then score post-edge state.
  task automatic run_cycle(input string name, input vec_t v);
    exp_t e;
    reset = v.rst; stall = v.stl; d_valid = v.dv; sel = v.sl; cmp = v.cp;
    pc_d = v.pcd; imm26 = v.imm; jr = v.jrv;
    @(negedge clk);
    check32({name, " redirect"}, {31'b0, redirect}, {31'b0, v.e_redir});
    check32({name, " pc8_d"}, pc8_d, v.pcd + 32'd8);
    sb.push_back('{name, v.e_pc, v.e_pend});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s scoreboard: empty queue, expected one entry", name);
    end else begin
      e = sb.pop_front();
      check32({e.name, " pc_f"}, pc_f, e.pc);
      check32({e.name, " pc4_f"}, pc4_f, e.pc + 32'd4);
      check32({e.name, " pend_v"}, {31'b0, pend_v}, {31'b0, e.pend});
      check32({e.name, " adel_f"}, {31'b0, adel_f}, {31'b0, adel_model(e.pc)});
    end
  endtask

  initial begin
    //  rst stl dv sel cmp pc_d        imm26        jr            redir pc_f after   pend
    add(0, 0, 0, 3'd0, 0, 32'h0,    26'h0,       32'h0,        0, 32'h0000_3004, 0);
    add(0, 0, 0, 3'd0, 0, 32'h0,    26'h0,       32'h0,        0, 32'h0000_3008, 0);
    add(0, 0, 1, 3'd1, 1, 32'h3010, 26'h000FFFC, 32'h0,        1, 32'h0000_3004, 0);
    add(0, 0, 1, 3'd1, 0, 32'h3010, 26'h000FFFC, 32'h0,        0, 32'h0000_3008, 0);
    add(0, 0, 1, 3'd1, 1, 32'h3010, 26'h0000010, 32'h0,        1, 32'h0000_3054, 0);
    add(0, 0, 1, 3'd2, 0, 32'h3020, 26'h0000C40, 32'h0,        1, 32'h0000_3100, 0);
    add(0, 0, 1, 3'd5, 1, 32'h3020, 26'h0000C40, 32'h3400,     0, 32'h0000_3104, 0);
    add(0, 0, 0, 3'd3, 0, 32'h3020, 26'h0,       32'h3400,     0, 32'h0000_3108, 0);
    add(0, 1, 1, 3'd3, 0, 32'h3100, 26'h0,       32'h3400,     1, 32'h0000_3108, 1);
    add(0, 1, 0, 3'd0, 0, 32'h0,    26'h0,       32'h0,        0, 32'h0000_3108, 1);
    add(0, 1, 0, 3'd0, 0, 32'h0,    26'h0,       32'h0,        0, 32'h0000_3108, 1);
    add(0, 0, 0, 3'd0, 0, 32'h0,    26'h0,       32'h0,        0, 32'h0000_3400, 0);
    add(0, 0, 0, 3'd0, 0, 32'h0,    26'h0,       32'h0,        0, 32'h0000_3404, 0);
    add(0, 1, 1, 3'd3, 0, 32'h3400, 26'h0,       32'h3400,     1, 32'h0000_3404, 1);
    add(0, 1, 1, 3'd3, 0, 32'h3400, 26'h0,       32'h3500,     1, 32'h0000_3404, 1);
    add(0, 1, 0, 3'd0, 0, 32'h0,    26'h0,       32'h0,        0, 32'h0000_3404, 1);
    add(0, 0, 0, 3'd0, 0, 32'h0,    26'h0,       32'h0,        0, 32'h0000_3500, 0);
    add(0, 1, 1, 3'd3, 0, 32'h3500, 26'h0,       32'h3400,     1, 32'h0000_3500, 1);
    add(0, 0, 1, 3'd3, 0, 32'h3500, 26'h0,       32'h3600,     1, 32'h0000_3600, 0);
    add(0, 1, 1, 3'd3, 0, 32'h3600, 26'h0,       32'h3700,     1, 32'h0000_3600, 1);
    add(1, 1, 0, 3'd0, 0, 32'h0,    26'h0,       32'h0,        0, 32'h0000_3000, 0);
    add(0, 0, 0, 3'd0, 0, 32'h0,    26'h0,       32'h0,        0, 32'h0000_3004, 0);
    add(0, 0, 1, 3'd3, 0, 32'h3004, 26'h0,       32'h3002,     1, 32'h0000_3002, 0);
    add(0, 0, 1, 3'd3, 0, 32'h3004, 26'h0,       32'h7000,     1, 32'h0000_7000, 0);
    add(0, 0, 1, 3'd3, 0, 32'h3004, 26'h0,       32'h3004,     1, 32'h0000_3004, 0);
    add(0, 0, 1, 3'd3, 0, 32'h3004, 26'h0,       32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 0);
    add(0, 0, 0, 3'd0, 0, 32'h0,    26'h0,       32'h0,        0, 32'hFFFF_FFFC, 0);
    add(0, 0, 0, 3'd0, 0, 32'h0,    26'h0,       32'h0,        0, 32'h0000_0000, 0);
    add(0, 0, 0, 3'd0, 0, 32'h0,    26'h0,       32'h0,        0, 32'h0000_0004, 0);

    reset = 1'b1; stall = 1'b0; d_valid = 1'b0; sel = 3'd0; cmp = 1'b0;
    pc_d = '0; imm26 = '0; jr = '0;
    repeat (2) @(posedge clk);
    #1;
    check32("reset pc_f", pc_f, 32'h0000_3000);
    check32("reset pend_v", {31'b0, pend_v}, 32'd0);
    check32("reset adel_f", {31'b0, adel_f}, {31'b0, adel_model(32'h3000)});

    for (int i = 0; i < vecs.size(); i++) begin
      run_cycle($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset held across a stalled redirect: nothing may leak into PEND.
    run_cycle("hold_stall_jr", '{0, 1, 1, 3'd3, 0, 32'h4, 26'h0, 32'h3800, 1, 32'h0000_0004, 1});
    run_cycle("rst_a", '{1, 1, 1, 3'd3, 0, 32'h4, 26'h0, 32'h3900, 1, 32'h0000_3000, 0});
    run_cycle("rst_b", '{1, 0, 1, 3'd2, 0, 32'h4, 26'h0000C40, 32'h0, 1, 32'h0000_3000, 0});
    run_cycle("post_rst", '{0, 0, 0, 3'd0, 0, 32'h0, 26'h0, 32'h0, 0, 32'h0000_3004, 0});
    run_cycle("stall_idle", '{0, 1, 0, 3'd0, 0, 32'h0, 26'h0, 32'h0, 0, 32'h0000_3004, 0});
    run_cycle("release", '{0, 0, 0, 3'd0, 0, 32'h0, 26'h0, 32'h0, 0, 32'h0000_3008, 0});

    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
